split_byte_mem: RTL and testbench



---
 rtl/split_byte_mem.sv | 70 +++++++
 tb/tb_split_byte_mem.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/split_byte_mem.sv
// Byte-lane controller: maps a 16-bit byte-addressed CPU port onto two 8-bit BRAM banks.
// Even byte addresses live in the low bank and odd byte addresses in the high bank (little-endian).
module split_byte_mem #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr,
  input  logic                  byt,
  input  logic [15:0]           wr_data,
  output logic [15:0]           rd_data,
  output logic                  bram_clk,
  output logic                  bram_rst,
  output logic                  wr_lo,
  output logic                  wr_hi,
  output logic [ADDR_WIDTH-2:0] addr_lo,
  output logic [ADDR_WIDTH-2:0] addr_hi,
  output logic [7:0]            wr_data_lo,
  output logic [7:0]            wr_data_hi,
  input  logic [7:0]            rd_data_lo,
  input  logic [7:0]            rd_data_hi
);

  localparam int BANK_AW = ADDR_WIDTH - 1;

  logic a0_d;
  logic byt_d;

  assign bram_clk = clk;
  assign bram_rst = rst;

  // An odd address starts in the high bank, so its upper byte sits in the next low-bank
  // word; the add wraps naturally at the top of the bank.
  assign addr_hi = addr[ADDR_WIDTH-1:1];
  assign addr_lo = addr[ADDR_WIDTH-1:1] + {{(BANK_AW-1){1'b0}}, addr[0]};

  always_comb begin
    wr_data_lo = wr_data[7:0];
    wr_data_hi = wr_data[15:8];
    if (addr[0]) begin
      wr_data_lo = wr_data[15:8];
      wr_data_hi = wr_data[7:0];
    end
  end

  assign wr_lo = wr & (~byt | ~addr[0]);
  assign wr_hi = wr & (~byt |  addr[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a0_d  <= 1'b0;
      byt_d <= 1'b0;
    end else begin
      a0_d  <= addr[0];
      byt_d <= byt;
    end
  end

  // Lane steering for the data returned by the banks one cycle after the address.
  always_comb begin
    rd_data = {rd_data_hi, rd_data_lo};
    if (byt_d) begin
      rd_data = {8'h00, (a0_d ? rd_data_hi : rd_data_lo)};
    end else if (a0_d) begin
      rd_data = {rd_data_lo, rd_data_hi};
    end
  end

endmodule

// File: tb/tb_split_byte_mem.sv
// Bench for split_byte_mem: behavioural byte-wide BRAM banks, directed accesses,
// read results checked through an expected-value queue popped by a separate monitor.
module tb_split_byte_mem;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          wr;
  logic          byt;
  logic [15:0]   wr_data;
  logic [15:0]   rd_data;
  logic          bram_clk;
  logic          bram_rst;
  logic          wr_lo;
  logic          wr_hi;
  logic [AW-2:0] addr_lo;
  logic [AW-2:0] addr_hi;
  logic [7:0]    wr_data_lo;
  logic [7:0]    wr_data_hi;
  logic [7:0]    rd_data_lo;
  logic [7:0]    rd_data_hi;

  int total = 0;
  int bad = 0;

  logic        chk_now = 1'b0;
  logic [15:0] exp_q[$];

  logic [7:0] mem_lo [0:(1<<(AW-1))-1];
  logic [7:0] mem_hi [0:(1<<(AW-1))-1];

  always #5 clk = ~clk;

  split_byte_mem #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .byt(byt), .wr_data(wr_data),
    .rd_data(rd_data), .bram_clk(bram_clk), .bram_rst(bram_rst),
    .wr_lo(wr_lo), .wr_hi(wr_hi), .addr_lo(addr_lo), .addr_hi(addr_hi),
    .wr_data_lo(wr_data_lo), .wr_data_hi(wr_data_hi),
    .rd_data_lo(rd_data_lo), .rd_data_hi(rd_data_hi)
  );

  // Registered-output banks, read-before-write, output cleared by reset.
  always @(posedge bram_clk or posedge bram_rst) begin
    if (bram_rst) begin
      rd_data_lo <= 8'h00;
      rd_data_hi <= 8'h00;
    end else begin
      rd_data_lo <= mem_lo[addr_lo];
      rd_data_hi <= mem_hi[addr_hi];
      if (wr_lo) mem_lo[addr_lo] <= wr_data_lo;
      if (wr_hi) mem_hi[addr_hi] <= wr_data_hi;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: a read issued at this edge shows up on rd_data just after it.
  initial begin
    logic        pend;
    logic [15:0] e;
    forever begin
      @(posedge clk);
      pend = chk_now;
      #1;
      if (pend) begin
        if (exp_q.size() == 0) begin
          cmp("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          cmp("rd_data", 32'(rd_data), 32'(e));
        end
      end
    end
  end

  task automatic drive(input logic [AW-1:0] a, input logic w, input logic b,
                       input logic [15:0] d, input logic c, input logic [15:0] e);
    @(negedge clk);
    addr = a; wr = w; byt = b; wr_data = d; chk_now = c;
    if (c) exp_q.push_back(e);
    #1;
  endtask

  task automatic bank_side(input string name, input logic el, input logic eh,
                           input logic [AW-2:0] al, input logic [AW-2:0] ah,
                           input logic [7:0] dl, input logic [7:0] dh);
    cmp({name, "_wr_lo"}, 32'(wr_lo), 32'(el));
    cmp({name, "_wr_hi"}, 32'(wr_hi), 32'(eh));
    cmp({name, "_addr_lo"}, 32'(addr_lo), 32'(al));
    cmp({name, "_addr_hi"}, 32'(addr_hi), 32'(ah));
    if (el) cmp({name, "_wd_lo"}, 32'(wr_data_lo), 32'(dl));
    if (eh) cmp({name, "_wd_hi"}, 32'(wr_data_hi), 32'(dh));
  endtask

  initial begin
    rst = 1'b1; addr = '0; wr = 1'b0; byt = 1'b0; wr_data = 16'h0000;
    #2;
    cmp("reset_rd_data", 32'(rd_data), 32'h0);
    cmp("bram_rst_follow", 32'(bram_rst), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    // Aligned word write, then read back.
    drive(13'h0300, 1'b1, 1'b0, 16'hABCD, 1'b0, 16'h0);
    bank_side("wwr_300", 1'b1, 1'b1, 12'h180, 12'h180, 8'hCD, 8'hAB);
    @(posedge clk); #1;
    cmp("mem_lo_180", 32'(mem_lo[12'h180]), 32'hCD);
    cmp("mem_hi_180", 32'(mem_hi[12'h180]), 32'hAB);
    drive(13'h0300, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hABCD);
    bank_side("wrd_300", 1'b0, 1'b0, 12'h180, 12'h180, 8'h00, 8'h00);

    // Byte write to odd address touches only the high bank.
    drive(13'h0301, 1'b1, 1'b1, 16'hFF5A, 1'b0, 16'h0);
    bank_side("bwr_301", 1'b0, 1'b1, 12'h181, 12'h180, 8'h00, 8'h5A);
    @(posedge clk); #1;
    cmp("mem_hi_180_b", 32'(mem_hi[12'h180]), 32'h5A);
    cmp("mem_lo_180_keep", 32'(mem_lo[12'h180]), 32'hCD);

    // Back-to-back reads: word, odd byte, even byte.
    drive(13'h0300, 1'b0, 1'b0, 16'h0, 1'b1, 16'h5ACD);
    drive(13'h0301, 1'b0, 1'b1, 16'h0, 1'b1, 16'h005A);
    drive(13'h0300, 1'b0, 1'b1, 16'h0, 1'b1, 16'h00CD);

    // Unaligned word write spans hi[0x180] and lo[0x181].
    drive(13'h0301, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0);
    bank_side("uwr_301", 1'b1, 1'b1, 12'h181, 12'h180, 8'h12, 8'h34);
    drive(13'h0301, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234);
    drive(13'h0300, 1'b0, 1'b0, 16'h0, 1'b1, 16'h34CD);

    // Byte write to even address touches only the low bank.
    drive(13'h0302, 1'b1, 1'b1, 16'hEE77, 1'b0, 16'h0);
    bank_side("bwr_302", 1'b1, 1'b0, 12'h181, 12'h181, 8'h77, 8'h00);
    drive(13'h0302, 1'b0, 1'b1, 16'h0, 1'b1, 16'h0077);
    drive(13'h0301, 1'b0, 1'b0, 16'h0, 1'b1, 16'h7734);

    // Top odd address: low-bank address wraps to 0.
    drive(13'h1FFF, 1'b1, 1'b0, 16'hBEEF, 1'b0, 16'h0);
    bank_side("wrap_wr", 1'b1, 1'b1, 12'h000, 12'hFFF, 8'hBE, 8'hEF);
    drive(13'h1FFF, 1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF);
    drive(13'h1FFF, 1'b0, 1'b1, 16'h0, 1'b1, 16'h00EF);
    drive(13'h0000, 1'b0, 1'b1, 16'h0, 1'b1, 16'h00BE);

    // Reset mid-stream after an odd byte read, then recover.
    drive(13'h0301, 1'b0, 1'b1, 16'h0, 1'b1, 16'h0034);
    drive(13'h0301, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("rst_mid_rd_data", 32'(rd_data), 32'h0);
    @(posedge clk); #1;
    cmp("rst_hold_rd_data", 32'(rd_data), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    addr = 13'h0300; byt = 1'b0; chk_now = 1'b1;
    exp_q.push_back(16'h34CD);
    drive(13'h0000, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      cmp("queue_drain", 32'(exp_q.size()), 32'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
